// File: rtl/drone_mem_pkg.sv
// Shared types and limits for the flight-controller system RAM family.
package drone_mem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  localparam int RAM_DEF_DATA_W = 8;
  localparam int RAM_DEF_ADDR_W = 8;

  localparam int RAM_MIN_RD_LAT = 1;
  localparam int RAM_MAX_RD_LAT = 2;

  function automatic bit ram_params_ok(input int rd_latency, input int depth, input int addr_w);
    return (rd_latency >= RAM_MIN_RD_LAT) && (rd_latency <= RAM_MAX_RD_LAT) &&
           (depth >= 1) && (longint'(depth) <= (longint'(1) << addr_w));
  endfunction

endpackage

// File: rtl/sys_ram_array.sv
// Bare inferable RAM: one write port, one registered read port (1 cycle).
// Read output holds while re=0; WRITE_FIRST selects new or old data on same-address collision.
module sys_ram_array #(
  parameter int DATA_W      = 8,
  parameter int IDX_W       = 8,
  parameter int DEPTH       = 256,
  parameter int WRITE_FIRST = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  if (WRITE_FIRST != 0) begin : g_write_first
    always_ff @(posedge clk) begin
      if (re) begin
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
      end
    end
  end else begin : g_read_first
    always_ff @(posedge clk) begin
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/sys_ram_dp.sv
// Simple-dual-port system RAM with clear-after-reset, range checks and 1/2-cycle read latency.
// No backpressure: one read and one write per cycle; accesses are dropped while busy.
module sys_ram_dp
  import drone_mem_pkg::*;
#(
  parameter int DATA_W         = RAM_DEF_DATA_W,
  parameter int ADDR_W         = RAM_DEF_ADDR_W,
  parameter int DEPTH          = 256,
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk_system,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              err_oob
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  always_ff @(posedge clk_system) begin
    assert (ram_params_ok(RD_LATENCY, DEPTH, ADDR_W))
      else $fatal(1, "sys_ram_dp: RD_LATENCY must be 1..2 and DEPTH 1..2**ADDR_W");
  end

  ram_state_t       state, state_nxt;
  logic [IDX_W-1:0] clr_addr, clr_addr_nxt;

  always_ff @(posedge clk_system) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    if (state == ST_CLEAR) begin
      clr_addr_nxt = clr_addr + IDX_W'(1);
      if (clr_addr == LAST_IDX) begin
        state_nxt    = ST_READY;
        clr_addr_nxt = '0;
      end
    end
  end

  logic ready, acc_en, rd_acc, wr_acc, rd_oob, wr_oob;

  assign ready  = (state == ST_READY);
  assign busy   = ~ready;
  assign acc_en = ready & ~reset;
  assign rd_acc = acc_en & rd;
  assign wr_acc = acc_en & wr;
  // Full-width compare so that DEPTH == 2**ADDR_W can never flag.
  assign rd_oob = ({1'b0, rd_addr} >= DEPTH_V);
  assign wr_oob = ({1'b0, wr_addr} >= DEPTH_V);

  logic              arr_we, arr_re;
  logic [IDX_W-1:0]  arr_waddr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;

  always_comb begin
    arr_we    = wr_acc & ~wr_oob;
    arr_waddr = wr_addr[IDX_W-1:0];
    arr_wdata = wr_data;
    if (state == ST_CLEAR) begin
      arr_we    = 1'b1;
      arr_waddr = clr_addr;
      arr_wdata = '0;
    end
  end

  assign arr_re = rd_acc & ~rd_oob;

  sys_ram_array #(
    .DATA_W      (DATA_W),
    .IDX_W       (IDX_W),
    .DEPTH       (DEPTH),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_array (
    .clk   (clk_system),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (rd_addr[IDX_W-1:0]),
    .rdata (arr_rdata)
  );

  // s1_sel picks the array output or zero (last read was out of range / after reset);
  // the array register itself holds between reads, so this also holds rd_data.
  logic              s1_vld, s1_err, s1_sel;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clk_system) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_err <= 1'b0;
      s1_sel <= 1'b0;
    end else begin
      s1_vld <= rd_acc;
      s1_err <= (rd_acc & rd_oob) | (wr_acc & wr_oob);
      if (rd_acc) begin
        s1_sel <= ~rd_oob;
      end
    end
  end

  assign s1_data = s1_sel ? arr_rdata : '0;

  if (RD_LATENCY == 2) begin : g_lat2
    always_ff @(posedge clk_system) begin
      if (reset) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
        err_oob  <= 1'b0;
      end else begin
        rd_valid <= s1_vld;
        err_oob  <= s1_err;
        if (s1_vld) begin
          rd_data <= s1_data;
        end
      end
    end
  end else begin : g_lat1
    assign rd_data  = s1_data;
    assign rd_valid = s1_vld;
    assign err_oob  = s1_err;
  end

endmodule

// File: tb/tb_sys_ram_dp.sv
// Bench for sys_ram_dp: four parameter variants share one stimulus stream, each checked
// every cycle against an event-level reference model, plus directed spot checks.
module tb_sys_ram_dp;

  localparam int NI = 4;
  localparam int P_DEPTH [NI] = '{256, 256, 200, 16};
  localparam int P_LAT   [NI] = '{1, 2, 1, 2};
  localparam int P_WF    [NI] = '{1, 0, 1, 0};
  localparam int P_CLR   [NI] = '{1, 1, 1, 0};

  logic       clk = 1'b0;
  logic       rst, rd, wr;
  logic [7:0] ra, wa, wd;

  logic [7:0] o_data  [NI];
  logic       o_valid [NI];
  logic       o_busy  [NI];
  logic       o_oob   [NI];

  always #5 clk = ~clk;

  sys_ram_dp #(.DATA_W(8), .ADDR_W(8), .DEPTH(P_DEPTH[0]), .RD_LATENCY(P_LAT[0]),
               .WRITE_FIRST(P_WF[0]), .CLEAR_ON_RESET(P_CLR[0])) dut_a (
    .clk_system(clk), .reset(rst), .rd_addr(ra), .rd(rd), .wr_addr(wa), .wr(wr), .wr_data(wd),
    .rd_data(o_data[0]), .rd_valid(o_valid[0]), .busy(o_busy[0]), .err_oob(o_oob[0]));

  sys_ram_dp #(.DATA_W(8), .ADDR_W(8), .DEPTH(P_DEPTH[1]), .RD_LATENCY(P_LAT[1]),
               .WRITE_FIRST(P_WF[1]), .CLEAR_ON_RESET(P_CLR[1])) dut_b (
    .clk_system(clk), .reset(rst), .rd_addr(ra), .rd(rd), .wr_addr(wa), .wr(wr), .wr_data(wd),
    .rd_data(o_data[1]), .rd_valid(o_valid[1]), .busy(o_busy[1]), .err_oob(o_oob[1]));

  sys_ram_dp #(.DATA_W(8), .ADDR_W(8), .DEPTH(P_DEPTH[2]), .RD_LATENCY(P_LAT[2]),
               .WRITE_FIRST(P_WF[2]), .CLEAR_ON_RESET(P_CLR[2])) dut_c (
    .clk_system(clk), .reset(rst), .rd_addr(ra), .rd(rd), .wr_addr(wa), .wr(wr), .wr_data(wd),
    .rd_data(o_data[2]), .rd_valid(o_valid[2]), .busy(o_busy[2]), .err_oob(o_oob[2]));

  sys_ram_dp #(.DATA_W(8), .ADDR_W(8), .DEPTH(P_DEPTH[3]), .RD_LATENCY(P_LAT[3]),
               .WRITE_FIRST(P_WF[3]), .CLEAR_ON_RESET(P_CLR[3])) dut_d (
    .clk_system(clk), .reset(rst), .rd_addr(ra), .rd(rd), .wr_addr(wa), .wr(wr), .wr_data(wd),
    .rd_data(o_data[3]), .rd_valid(o_valid[3]), .busy(o_busy[3]), .err_oob(o_oob[3]));

  // Reference model: memory image, remaining clear cycles, and results scheduled by edge number.
  logic [7:0] mmem    [NI][256];
  bit         mknown  [NI][256];
  int         cnt     [NI];
  bit         sl_use  [NI][4];
  bit         sl_v    [NI][4];
  bit         sl_o    [NI][4];
  bit         sl_k    [NI][4];
  logic [7:0] sl_d    [NI][4];
  bit         e_valid [NI];
  bit         e_oob   [NI];
  bit         e_known [NI];
  logic [7:0] e_data  [NI];
  int         edge_n = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %h expected %h at edge %0d", tag, k, obs, exp, edge_n);
    end
  endtask

  task automatic take_slot(input int k);
    int s;
    s = edge_n % 4;
    if (sl_use[k][s]) begin
      e_valid[k] = sl_v[k][s];
      e_oob[k]   = sl_o[k][s];
      if (sl_v[k][s]) begin
        e_data[k]  = sl_d[k][s];
        e_known[k] = sl_k[k][s];
      end
      sl_use[k][s] = 1'b0;
    end else begin
      e_valid[k] = 1'b0;
      e_oob[k]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        for (int s = 0; s < 4; s++) sl_use[k][s] = 1'b0;
        e_valid[k] = 1'b0;
        e_oob[k]   = 1'b0;
        e_data[k]  = 8'h00;
        e_known[k] = 1'b1;
        if (P_CLR[k] != 0) begin
          cnt[k] = P_DEPTH[k];
          for (int a = 0; a < 256; a++) begin
            mmem[k][a]   = 8'h00;
            mknown[k][a] = 1'b1;
          end
        end else begin
          cnt[k] = 0;
        end
      end else if (cnt[k] > 0) begin
        cnt[k]--;
        take_slot(k);
      end else begin
        bit         rv, ro, rk;
        logic [7:0] rdv;
        int         s;
        rv = 1'b0; ro = 1'b0; rk = 1'b1; rdv = 8'h00;
        if (rd) begin
          rv = 1'b1;
          if (ra >= P_DEPTH[k]) ro = 1'b1;
          else if (wr && wa == ra && P_WF[k] != 0) rdv = wd;
          else begin
            rdv = mmem[k][ra];
            rk  = mknown[k][ra];
          end
        end
        if (wr && wa >= P_DEPTH[k]) ro = 1'b1;
        if (wr && wa < P_DEPTH[k]) begin
          mmem[k][wa]   = wd;
          mknown[k][wa] = 1'b1;
        end
        if (rv || ro) begin
          s = (edge_n + P_LAT[k] - 1) % 4;
          sl_use[k][s] = 1'b1;
          sl_v[k][s]   = rv;
          sl_o[k][s]   = ro;
          sl_d[k][s]   = rdv;
          sl_k[k][s]   = rk;
        end
        take_slot(k);
      end
    end
    edge_n++;
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk("busy", k, o_busy[k], cnt[k] > 0);
      chk("rd_valid", k, o_valid[k], e_valid[k]);
      chk("err_oob", k, o_oob[k], e_oob[k]);
      if (e_known[k]) chk("rd_data", k, o_data[k], e_data[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; ra = 8'h00; wa = 8'h00; wd = 8'h00;

    // Reset 2 cycles, then the default-parameter clear takes exactly 256 cycles.
    step(); step();
    chk("reset_rd_data", 0, o_data[0], 8'h00);
    rst = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      step();
      chk("clear_busy", 0, o_busy[0], i < 256);
    end
    chk("nodepth_clr_busy", 3, o_busy[3], 1'b0);

    rd = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ra = 8'(i);
      step();
      chk("cleared_valid", 0, o_valid[0], 1'b1);
      chk("cleared_data", 0, o_data[0], 8'h00);
    end

    // Simple write/readback.
    rd = 1'b0; wr = 1'b1; wa = 8'h00; wd = 8'h72;
    step();
    chk("wr_no_valid", 0, o_valid[0], 1'b0);
    wr = 1'b0; rd = 1'b1; ra = 8'h00;
    step();
    chk("rb_valid", 0, o_valid[0], 1'b1);
    chk("rb_72", 0, o_data[0], 8'h72);
    ra = 8'h01;
    step();
    chk("rb_01_zero", 0, o_data[0], 8'h00);
    rd = 1'b0; wr = 1'b1; wa = 8'h01; wd = 8'hAA;
    step();
    wr = 1'b0; rd = 1'b1; ra = 8'h01;
    step();
    chk("rb_aa", 0, o_data[0], 8'hAA);

    // Back-to-back reads through the 2-cycle variant.
    rd = 1'b0;
    step();
    rd = 1'b1; ra = 8'h00;
    step();
    chk("lat2_not_yet", 1, o_valid[1], 1'b0);
    ra = 8'h01;
    step();
    chk("lat2_v0", 1, o_valid[1], 1'b1);
    chk("lat2_d0", 1, o_data[1], 8'h72);
    ra = 8'h00;
    step();
    chk("lat2_v1", 1, o_valid[1], 1'b1);
    chk("lat2_d1", 1, o_data[1], 8'hAA);
    rd = 1'b0;
    step();
    chk("lat2_v2", 1, o_valid[1], 1'b1);
    chk("lat2_d2", 1, o_data[1], 8'h72);
    step();
    chk("lat2_done", 1, o_valid[1], 1'b0);

    // Same-address collision in write-first and read-first variants.
    wr = 1'b1; wa = 8'h10; wd = 8'h11;
    step();
    rd = 1'b1; ra = 8'h10; wd = 8'h22;
    step();
    chk("coll_wf", 0, o_data[0], 8'h22);
    wr = 1'b0;
    step();
    chk("coll_rf", 1, o_data[1], 8'h11);
    chk("after_coll_wf", 0, o_data[0], 8'h22);
    rd = 1'b0;
    step();
    chk("after_coll_rf", 1, o_data[1], 8'h22);

    // Range checks on the 200-word variant.
    wr = 1'b1; wa = 8'hC8; wd = 8'h5A;
    step();
    chk("oob_wr", 2, o_oob[2], 1'b1);
    chk("oob_wr_novalid", 2, o_valid[2], 1'b0);
    wr = 1'b0; rd = 1'b1; ra = 8'hC8;
    step();
    chk("oob_rd_valid", 2, o_valid[2], 1'b1);
    chk("oob_rd_data", 2, o_data[2], 8'h00);
    chk("oob_rd_err", 2, o_oob[2], 1'b1);
    ra = 8'hC7;
    step();
    chk("inrange_err", 2, o_oob[2], 1'b0);
    rd = 1'b0;
    step();

    // Reset in the middle of the clear restarts it; accesses during busy are dropped.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0; rd = 1'b1; ra = 8'h10; wr = 1'b1; wa = 8'h10; wd = 8'h99;
    for (int i = 1; i <= 256; i++) begin
      step();
      chk("restart_busy", 0, o_busy[0], i < 256);
      chk("busy_no_valid", 0, o_valid[0], 1'b0);
    end
    wr = 1'b0;
    step();
    chk("post_clear_valid", 0, o_valid[0], 1'b1);
    chk("post_clear_data", 0, o_data[0], 8'h00);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
      wa  = ($urandom_range(0, 3) == 0) ? ra :
            (($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31)));
      wd  = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
